// File: rtl/charlie_scan_ctrl.sv
// -----------------------------------------------------------------------------
// charlie_scan_ctrl
//
// Scan scheduler for the charlieplex LED driver. It sits between the SPI
// register file and the `charlie` block, and it is the source of
// charlie_index. It walks LED indices 0..NUM_LEDS-1. Each LED gets a slot made
// of a blanking period, a dwell period and a single advance cycle. During the
// dwell period a duty-cycle gate sets the brightness. LEDs that are dark can
// be skipped. The frame is double-buffered: the SPI side presents a shadow
// frame on fb_in and pulses swap_req. The shadow frame is adopted only at a
// frame boundary, which is entry to slot 0, so a displayed frame never tears.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   enable         scan enable; low forces IDLE on the next cycle
//   cfg_dwell      on-slot length minus 1, in clocks
//   cfg_duty       clocks of the on-slot during which the LED is lit
//   cfg_blank      blanking clocks before each slot (0 = no blank)
//   cfg_skip_dark  bypass blank/dwell for LEDs whose frame bit is 0
//   fb_in          shadow frame from the SPI registers
//   swap_req       one-cycle request to adopt fb_in at the next boundary
//   charlie_index  LED index presented to the driver
//   led_on         driver gate; LED charlie_index is lit only when 1
//   active_fb      frame currently being displayed
//   frame_start    one-cycle pulse on the first cycle of slot 0
//   swap_ack       one-cycle pulse when a swap is committed
//   busy           1 whenever the scheduler is not IDLE
//
// Every output comes straight from a register. The next-state logic computes
// the value that each register will hold in the next cycle, and that includes
// led_on. This means led_on always matches the state, index and counter that
// are shown in the same cycle.
// -----------------------------------------------------------------------------
module charlie_scan_ctrl #(
  parameter int NUM_LEDS = 56,
  parameter int IDX_W    = 6,
  parameter int FB_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       cfg_dwell,
  input  logic [7:0]       cfg_duty,
  input  logic [3:0]       cfg_blank,
  input  logic             cfg_skip_dark,
  input  logic [FB_W-1:0]  fb_in,
  input  logic             swap_req,
  output logic [IDX_W-1:0] charlie_index,
  output logic             led_on,
  output logic [FB_W-1:0]  active_fb,
  output logic             frame_start,
  output logic             swap_ack,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_DWELL   = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  // The index that follows idx. The highest LED wraps back to 0, so indices at
  // or above NUM_LEDS are never produced.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = IDX_ZERO;
    end else begin
      nxt = idx + IDX_ONE;
    end
    return nxt;
  endfunction

  // Registered state
  state_t           state_r;
  logic [IDX_W-1:0] index_r;
  logic [3:0]       blank_cnt_r;
  logic [7:0]       dwell_cnt_r;
  logic [7:0]       slot_dwell_r;
  logic [7:0]       slot_duty_r;
  logic [3:0]       slot_blank_r;
  logic [FB_W-1:0]  active_fb_r;
  logic             swap_pending_r;
  logic             led_on_r;
  logic             frame_start_r;
  logic             swap_ack_r;
  logic             busy_r;

  // Next-state values
  state_t           state_s;
  logic [IDX_W-1:0] index_s;
  logic [3:0]       blank_cnt_s;
  logic [7:0]       dwell_cnt_s;
  logic [7:0]       slot_dwell_s;
  logic [7:0]       slot_duty_s;
  logic [3:0]       slot_blank_s;
  logic [FB_W-1:0]  active_fb_s;
  logic             swap_pending_s;
  logic             led_on_s;
  logic             frame_start_s;
  logic             swap_ack_s;
  logic             busy_s;
  logic             slot_entry_s;
  logic             boundary_s;

  // Next-state logic: sequencing, frame swap and slot entry, then the gate
  always_comb begin
    state_s        = state_r;
    index_s        = index_r;
    blank_cnt_s    = blank_cnt_r;
    dwell_cnt_s    = dwell_cnt_r;
    slot_dwell_s   = slot_dwell_r;
    slot_duty_s    = slot_duty_r;
    slot_blank_s   = slot_blank_r;
    active_fb_s    = active_fb_r;
    swap_pending_s = swap_pending_r;
    frame_start_s  = 1'b0;
    swap_ack_s     = 1'b0;
    slot_entry_s   = 1'b0;
    boundary_s     = 1'b0;
    led_on_s       = 1'b0;
    busy_s         = 1'b0;

    // Sequencing. Dropping enable returns to IDLE at once, even in mid-slot.
    if (!enable) begin
      state_s     = ST_IDLE;
      index_s     = IDX_ZERO;
      blank_cnt_s = 4'd0;
      dwell_cnt_s = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Starting a scan always enters slot 0, so this is a frame boundary.
          index_s      = IDX_ZERO;
          slot_entry_s = 1'b1;
          boundary_s   = 1'b1;
        end
        ST_BLANK: begin
          // BLANK is entered only when slot_blank_r is nonzero, so subtracting
          // 1 here cannot underflow.
          if (blank_cnt_r == (slot_blank_r - 4'd1)) begin
            state_s     = ST_DWELL;
            blank_cnt_s = 4'd0;
            dwell_cnt_s = 8'd0;
          end else begin
            blank_cnt_s = blank_cnt_r + 4'd1;
          end
        end
        ST_DWELL: begin
          if (dwell_cnt_r == slot_dwell_r) begin
            state_s     = ST_ADVANCE;
            dwell_cnt_s = 8'd0;
          end else begin
            dwell_cnt_s = dwell_cnt_r + 8'd1;
          end
        end
        ST_ADVANCE: begin
          index_s      = next_index(index_r);
          slot_entry_s = 1'b1;
          boundary_s   = (index_r == LAST_IDX);
        end
        default: begin
          state_s     = ST_IDLE;
          index_s     = IDX_ZERO;
          blank_cnt_s = 4'd0;
          dwell_cnt_s = 8'd0;
        end
      endcase
    end

    // Frame swap. A request that arrives in the same cycle as a boundary is
    // committed at once. A request at any other time is remembered, and
    // repeated requests merge into a single pending commit. active_fb changes
    // only at a boundary, so it is never updated while IDLE.
    if (boundary_s) begin
      frame_start_s = 1'b1;
      if (swap_pending_r || swap_req) begin
        active_fb_s    = fb_in;
        swap_ack_s     = 1'b1;
        swap_pending_s = 1'b0;
      end else begin
        swap_pending_s = swap_pending_r;
      end
    end else if (swap_req) begin
      swap_pending_s = 1'b1;
    end else begin
      swap_pending_s = swap_pending_r;
    end

    // Slot entry. The configuration is captured here so that a change made in
    // mid-slot takes effect only at the next slot. The skip decision reads the
    // frame as it will be displayed; at a boundary this may be a frame that has
    // just been swapped in.
    if (slot_entry_s) begin
      slot_dwell_s = cfg_dwell;
      slot_duty_s  = cfg_duty;
      slot_blank_s = cfg_blank;
      blank_cnt_s  = 4'd0;
      dwell_cnt_s  = 8'd0;
      if (cfg_skip_dark && !active_fb_s[index_s]) begin
        state_s = ST_ADVANCE;
      end else if (cfg_blank == 4'd0) begin
        state_s = ST_DWELL;
      end else begin
        state_s = ST_BLANK;
      end
    end else begin
      slot_dwell_s = slot_dwell_r;
      slot_duty_s  = slot_duty_r;
      slot_blank_s = slot_blank_r;
    end

    // The LED is lit only in DWELL, only when its frame bit is set, and only
    // for the first slot_duty clocks. A duty larger than the dwell therefore
    // keeps the LED lit for the whole slot.
    if (state_s == ST_DWELL) begin
      led_on_s = active_fb_s[index_s] && (dwell_cnt_s < slot_duty_s);
    end else begin
      led_on_s = 1'b0;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      index_r        <= IDX_ZERO;
      blank_cnt_r    <= 4'd0;
      dwell_cnt_r    <= 8'd0;
      slot_dwell_r   <= 8'd0;
      slot_duty_r    <= 8'd0;
      slot_blank_r   <= 4'd0;
      active_fb_r    <= {FB_W{1'b0}};
      swap_pending_r <= 1'b0;
      led_on_r       <= 1'b0;
      frame_start_r  <= 1'b0;
      swap_ack_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      index_r        <= index_s;
      blank_cnt_r    <= blank_cnt_s;
      dwell_cnt_r    <= dwell_cnt_s;
      slot_dwell_r   <= slot_dwell_s;
      slot_duty_r    <= slot_duty_s;
      slot_blank_r   <= slot_blank_s;
      active_fb_r    <= active_fb_s;
      swap_pending_r <= swap_pending_s;
      led_on_r       <= led_on_s;
      frame_start_r  <= frame_start_s;
      swap_ack_r     <= swap_ack_s;
      busy_r         <= busy_s;
    end
  end

  assign charlie_index = index_r;
  assign led_on        = led_on_r;
  assign active_fb     = active_fb_r;
  assign frame_start   = frame_start_r;
  assign swap_ack      = swap_ack_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_charlie_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for charlie_scan_ctrl (NUM_LEDS=56). The bench drives
// inputs and samples outputs on the falling clock edge. Expected values are
// worked out by hand from the slot timing: a slot lasts blank+dwell+2 cycles,
// and a skipped slot lasts 1 cycle.
// -----------------------------------------------------------------------------
module tb_charlie_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  cfg_dwell = 8'd0;
  logic [7:0]  cfg_duty = 8'd0;
  logic [3:0]  cfg_blank = 4'd0;
  logic        cfg_skip_dark = 1'b0;
  logic [63:0] fb_in = 64'd0;
  logic        swap_req = 1'b0;
  logic [5:0]  charlie_index;
  logic        led_on;
  logic [63:0] active_fb;
  logic        frame_start;
  logic        swap_ack;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  charlie_scan_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_dwell     (cfg_dwell),
    .cfg_duty      (cfg_duty),
    .cfg_blank     (cfg_blank),
    .cfg_skip_dark (cfg_skip_dark),
    .fb_in         (fb_in),
    .swap_req      (swap_req),
    .charlie_index (charlie_index),
    .led_on        (led_on),
    .active_fb     (active_fb),
    .frame_start   (frame_start),
    .swap_ack      (swap_ack),
    .busy          (busy)
  );

  task automatic set_cfg(input logic [3:0] b, input logic [7:0] dw,
                         input logic [7:0] du, input logic sk);
    cfg_blank     = b;
    cfg_dwell     = dw;
    cfg_duty      = du;
    cfg_skip_dark = sk;
  endtask

  // Takes the block to IDLE and starts it again, with an optional swap. The
  // task returns on the falling edge of the first active cycle (cycle 0).
  task automatic restart(input logic [63:0] fb, input logic sw);
    @(negedge clk);
    enable   = 1'b0;
    swap_req = 1'b0;
    @(negedge clk);
    fb_in    = fb;
    swap_req = sw;
    enable   = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(4'd2, 8'd3, 8'd4, 1'b0);
    fb_in = ONES;
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (charlie_index !== 6'd0) begin n_bad++; $display("FAIL reset_index got %0d want 0", charlie_index); end
    n_cmp++; if (led_on !== 1'b0) begin n_bad++; $display("FAIL reset_led_on got %b want 0", led_on); end
    n_cmp++; if (active_fb !== 64'd0) begin n_bad++; $display("FAIL reset_active_fb got %h want 0", active_fb); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    n_cmp++; if (swap_ack !== 1'b0) begin n_bad++; $display("FAIL reset_swap_ack got %b want 0", swap_ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  // blank=2, dwell=3, duty=4: each slot is 7 cycles with led pattern 0,0,1,1,1,1,0
  task automatic test_first_frame();
    logic [9:0] got, exp;
    int ph;
    restart(ONES, 1'b1);
    n_cmp++; if (active_fb !== ONES) begin n_bad++; $display("FAIL first_active_fb got %h want %h", active_fb, ONES); end
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      ph  = c % 7;
      exp = {6'((c / 7) % 56), (ph >= 2 && ph <= 5), (c % 392 == 0), (c == 0), 1'b1};
      got = {charlie_index, led_on, frame_start, swap_ack, busy};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL first_frame c=%0d {idx,led,fs,ack,busy} got %h want %h", c, got, exp);
      end
    end
  endtask

  // dwell=7, blank=0: lit cycles per slot for duty 0,3,8,255 are 0,3,8,8
  task automatic test_duty();
    logic [7:0] duties [4];
    int         lit_exp [4];
    int         lit;
    duties  = '{8'd0, 8'd3, 8'd8, 8'd255};
    lit_exp = '{0, 3, 8, 8};
    for (int k = 0; k < 4; k++) begin
      set_cfg(4'd0, 8'd7, duties[k], 1'b0);
      restart(ONES, 1'b0);
      lit = 0;
      for (int c = 0; c < 9; c++) begin
        if (c > 0) @(negedge clk);
        if (led_on === 1'b1) lit++;
      end
      n_cmp++;
      if (lit !== lit_exp[k]) begin
        n_bad++;
        $display("FAIL duty_%0d lit cycles got %0d want %0d", duties[k], lit, lit_exp[k]);
      end
      @(negedge clk);
      n_cmp++;
      if (charlie_index !== 6'd1) begin
        n_bad++;
        $display("FAIL duty_%0d slot_period index got %0d want 1", duties[k], charlie_index);
      end
    end
  endtask

  // Only LEDs 0 and 8 are set: those slots take 3 cycles, the rest 1; frame = 60
  task automatic test_skip_dark();
    logic [5:0] e_idx [61];
    logic       e_led [61];
    logic [8:0] got, exp;
    int         p;
    p = 0;
    for (int i = 0; i < 56; i++) begin
      if (i == 0 || i == 8) begin
        e_idx[p] = 6'(i); e_led[p] = 1'b1;
        e_idx[p+1] = 6'(i); e_led[p+1] = 1'b1;
        e_idx[p+2] = 6'(i); e_led[p+2] = 1'b0;
        p = p + 3;
      end else begin
        e_idx[p] = 6'(i); e_led[p] = 1'b0;
        p = p + 1;
      end
    end
    e_idx[60] = 6'd0; e_led[60] = 1'b1;
    set_cfg(4'd0, 8'd1, 8'd255, 1'b1);
    restart(64'h0000_0000_0000_0101, 1'b1);
    n_cmp++; if (active_fb !== 64'h101) begin n_bad++; $display("FAIL skip_active_fb got %h want 101", active_fb); end
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) @(negedge clk);
      exp = {e_idx[c], e_led[c], (c == 0 || c == 60), (c == 0)};
      got = {charlie_index, led_on, frame_start, swap_ack};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL skip_dark c=%0d {idx,led,fs,ack} got %h want %h", c, got, exp);
      end
    end
  endtask

  // Two swap requests in mid-frame give a single ack at the next frame_start
  task automatic test_swap_mid_frame();
    logic [63:0] e_fb;
    logic [1:0]  got, exp;
    set_cfg(4'd0, 8'd1, 8'd255, 1'b1);
    restart(64'h0000_0000_0000_0101, 1'b1);
    for (int c = 0; c <= 120; c++) begin
      if (c > 0) @(negedge clk);
      e_fb = (c < 60) ? 64'h101 : 64'h3;
      exp  = {(c % 60 == 0), (c == 0 || c == 60)};
      got  = {frame_start, swap_ack};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL swap_mid c=%0d {fs,ack} got %b want %b", c, got, exp);
      end
      n_cmp++;
      if (active_fb !== e_fb) begin
        n_bad++;
        $display("FAIL swap_mid_fb c=%0d got %h want %h", c, active_fb, e_fb);
      end
      if (c == 10) begin fb_in = 64'h3; swap_req = 1'b1; end
      else if (c == 20) swap_req = 1'b1;
      else swap_req = 1'b0;
    end
  endtask

  // Drop enable in DWELL of LED 20. Then request a swap while IDLE; it must wait for the restart.
  task automatic test_enable_drop();
    logic [5:0] got, exp;
    set_cfg(4'd2, 8'd3, 8'd4, 1'b0);
    restart(ONES, 1'b1);
    for (int c = 1; c <= 143; c++) @(negedge clk);
    exp = {6'd20};
    n_cmp++;
    if ({charlie_index} !== exp || led_on !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_pre idx=%0d led=%b busy=%b want 20/1/1", charlie_index, led_on, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    got = {charlie_index};
    n_cmp++;
    if (got !== 6'd0 || led_on !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_idle idx=%0d led=%b busy=%b fs=%b want 0/0/0/0", charlie_index, led_on, busy, frame_start);
    end
    fb_in    = 64'h5;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    n_cmp++;
    if (active_fb !== ONES || swap_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_swap_held fb=%h ack=%b want %h/0", active_fb, swap_ack, ONES);
    end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_start !== 1'b1 || swap_ack !== 1'b1 || charlie_index !== 6'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reenable fs=%b ack=%b idx=%0d busy=%b want 1/1/0/1", frame_start, swap_ack, charlie_index, busy);
    end
    n_cmp++;
    if (active_fb !== 64'h5) begin
      n_bad++;
      $display("FAIL reenable_fb got %h want 5", active_fb);
    end
  endtask

  // Assert rst_n between clock edges while the LED is lit in DWELL
  task automatic test_async_reset();
    set_cfg(4'd2, 8'd3, 8'd4, 1'b0);
    restart(ONES, 1'b1);
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (led_on !== 1'b1) begin n_bad++; $display("FAIL areset_pre led got %b want 1", led_on); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({charlie_index, led_on, frame_start, swap_ack, busy} !== 10'd0 || active_fb !== 64'd0) begin
      n_bad++;
      $display("FAIL areset_clear idx=%0d led=%b fs=%b ack=%b busy=%b fb=%h want all 0",
               charlie_index, led_on, frame_start, swap_ack, busy, active_fb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (frame_start !== 1'b1 || swap_ack !== 1'b0 || busy !== 1'b1 || active_fb !== 64'd0) begin
      n_bad++;
      $display("FAIL areset_release fs=%b ack=%b busy=%b fb=%h want 1/0/1/0", frame_start, swap_ack, busy, active_fb);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_duty();
    test_skip_dark();
    test_swap_mid_frame();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/charlie_scan_ctrl.md
Name: charlie_scan_ctrl

Overview:
- Scan scheduler that sequences the charlieplex LED driver, sitting between the SPI register file and the `charlie` block.
- Replaces the free-running counter as the source of `charlie_index`.
- Walks LED indices with programmable blanking and dwell per LED, applies global duty-cycle brightness, and optionally skips dark LEDs.
- Double-buffers the 64-bit frame so SPI writes never tear a frame; the SPI side requests a swap and the swap happens only at a frame boundary.

Parameters:
- NUM_LEDS, 56, number of scanned LEDs (indices 0..NUM_LEDS-1); legal range 2..64
- IDX_W, 6, width of charlie_index
- FB_W, 64, frame-buffer width; bit i is LED i

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  scan enable (SPI control register bit)
- cfg_dwell  input  8  on-slot length minus 1, in clocks
- cfg_duty  input  8  clocks of the on-slot during which the LED is lit
- cfg_blank  input  4  blanking clocks before each slot; 0 means no blank
- cfg_skip_dark  input  1  skip slots whose frame bit is 0
- fb_in  input  FB_W  shadow frame from the SPI registers
- swap_req  input  1  one-cycle pulse requesting fb_in be adopted
- charlie_index  output  IDX_W  LED index presented to the driver
- led_on  output  1  gate: driver lights LED charlie_index only when 1
- active_fb  output  FB_W  frame currently being displayed
- frame_start  output  1  one-cycle pulse when index 0 begins
- swap_ack  output  1  one-cycle pulse when a swap is committed
- busy  output  1  1 whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, charlie_index=0, led_on=0, active_fb=0.
  - frame_start=0, swap_ack=0, swap_pending=0.
  - All counters=0.
- All outputs are registered.
- States: IDLE, BLANK, DWELL, ADVANCE.
- IDLE:
  - led_on=0, index=0.
  - When enable=1, the next cycle goes to BLANK (or DWELL if cfg_blank=0) for index 0, entering the frame boundary.
- Frame boundary (entry to slot 0, from IDLE or by wrap):
  - frame_start=1 for that cycle.
  - If swap_pending, or swap_req is high in the same cycle: active_fb<=fb_in, swap_ack=1 in that cycle, swap_pending cleared.
- Slot entry:
  - Latch cfg_dwell, cfg_duty, cfg_blank and cfg_skip_dark into slot-local registers.
  - Mid-slot config changes take effect at the next slot.
- BLANK:
  - led_on=0 for exactly cfg_blank cycles, charlie_index already showing the new index.
  - Then DWELL.
- DWELL:
  - dwell_cnt runs 0..cfg_dwell, so the slot lasts cfg_dwell+1 cycles.
  - led_on = active_fb[index] AND (dwell_cnt < cfg_duty).
  - cfg_duty=0 means always dark; cfg_duty>cfg_dwell means lit for the full slot.
  - After the cycle with dwell_cnt==cfg_dwell, go to ADVANCE.
- ADVANCE:
  - One cycle, led_on=0.
  - index<=index+1, or 0 if index==NUM_LEDS-1 (wrap is a frame boundary).
  - Then BLANK (or DWELL if blank=0).
- Skip dark:
  - If cfg_skip_dark=1 and active_fb[index]=0 on slot entry, BLANK and DWELL are bypassed.
  - The slot costs exactly 1 cycle (ADVANCE only).
  - If the whole frame is dark, index sweeps one LED per cycle and frame_start still pulses every NUM_LEDS cycles.
- swap_req while not at a boundary: set swap_pending. Repeated requests before commit collapse into one ack.
- swap_req while IDLE: committed on the next enable start boundary. active_fb is not updated while IDLE.
- enable falling mid-slot:
  - Next cycle state=IDLE, led_on=0, index=0.
  - swap_pending is retained.
- Indices >= NUM_LEDS are never emitted. Bits of active_fb at NUM_LEDS and above are ignored.
- Slot period (non-skipped) = cfg_blank + cfg_dwell + 2 cycles.

Test Plan:
- Reset with blank=2, dwell=3, duty=4, fb_in=all-ones, swap_req pulsed, enable=1 -> frame_start and swap_ack on the first active cycle; led_on pattern per slot is 0,0,1,1,1,1,0; index increments every 7 cycles; wraps 55->0 with frame_start.
- Duty scan with dwell=7 and duty in {0,3,8,255} -> led_on high for 0, 3, 8 and 8 cycles per slot respectively.
- skip_dark=1, fb=0x...0101 (LEDs 0 and 8 only), blank=0, dwell=1 -> only slots 0 and 8 are 3 cycles long, the other 54 are 1 cycle; frame period = 6+54 = 60 cycles.
- swap_req pulsed mid-frame with a new fb_in -> active_fb unchanged until wrap; swap_ack coincides with the next frame_start; a second swap_req in the same frame yields no extra ack.
- enable dropped during DWELL of index 20 -> next cycle busy=0, led_on=0, index=0; re-enable restarts at index 0 with frame_start.
- rst_n asserted asynchronously mid-DWELL with led_on=1 -> all outputs clear immediately, without waiting for a clock edge; no swap_ack is pending after release.
